// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / flush controller:
// stall vector width and encodings, controller state encoding, bus width.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    // Hold vector bit order: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB
    localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_LOADUSE = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EXBUSY  = 6'b001111;

    localparam int          REG_BUS   = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_EXBUSY = 2'b01,
        ST_FLUSH  = 2'b10
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline request inputs and control outputs around pipe_ctrl.
//
// Signalling: there is no valid/ready pair on this bundle. stallreq_id and
// flush_req are levels evaluated every cycle; ex_mc_start is a one-cycle
// pulse whose ex_mc_cycles is sampled in the same cycle; flush_pc is sampled
// only while flush_req=1. Outputs stall/ex_mc_done are combinational for the
// current cycle, flush/new_pc/busy derive from registered state. The
// requester (master) never waits on an acknowledgement; stall is the only
// back-pressure.
interface pipe_ctrl_if #(
    parameter int MC_CNT_W = 6
);
    import pipe_ctrl_pkg::*;

    logic                 stallreq_id;
    logic                 ex_mc_start;
    logic [MC_CNT_W-1:0]  ex_mc_cycles;
    logic                 flush_req;
    logic [REG_BUS-1:0]   flush_pc;

    logic [STALL_W-1:0]   stall;
    logic                 flush;
    logic [REG_BUS-1:0]   new_pc;
    logic                 ex_mc_done;
    logic                 busy;

    // Pipeline side: raises requests, obeys control outputs
    modport master (
        output stallreq_id, ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
        input  stall, flush, new_pc, ex_mc_done, busy
    );

    // Controller side
    modport slave (
        input  stallreq_id, ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
        output stall, flush, new_pc, ex_mc_done, busy
    );

endinterface

// File: rtl/pipe_ctrl_mc_down_counter.sv
// Down-counter tracking remaining EX occupancy of a multi-cycle operation.
// Load has priority over decrement; clear abandons any pending count.
module mc_down_counter #(
    parameter int MC_CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [MC_CNT_W-1:0] load_val,
    input  logic                dec,
    input  logic                clear,
    output logic [MC_CNT_W-1:0] count,
    output logic                one
);

    // Count register: clear > load > decrement, never wraps below zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - MC_CNT_W'(1);
        end
    end

    assign one = (count == MC_CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use stalls, multi-cycle EX occupancy and
// exception/redirect flushes. Three-state FSM (RUN, EXBUSY, FLUSH) with
// priority flush_req > ex_mc_start > stallreq_id.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus,
    output logic [1:0]  dbg_state
);

    state_t                state;
    state_t                state_next;
    logic [REG_BUS-1:0]    new_pc_q;
    logic [STALL_W-1:0]    stall_c;
    logic                  done_c;
    logic                  pc_capture;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_clear;
    logic [MC_CNT_W-1:0]   cnt_load_val;
    logic [MC_CNT_W-1:0]   cnt_value;
    logic                  cnt_one;
    logic                  mc_multi;

    // N of 0 or 1 is a single-cycle op that never occupies EX beyond its start
    assign mc_multi     = (bus.ex_mc_cycles >= MC_CNT_W'(2));
    // The start cycle itself counts toward N, so EXBUSY covers N-1 cycles
    assign cnt_load_val = bus.ex_mc_cycles - MC_CNT_W'(1);

    mc_down_counter #(
        .MC_CNT_W (MC_CNT_W)
    ) u_mc_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .clear    (cnt_clear),
        .count    (cnt_value),
        .one      (cnt_one)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Redirect target: captured with every accepted flush_req, held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            new_pc_q <= ZERO_WORD;
        end else if (pc_capture) begin
            new_pc_q <= bus.flush_pc;
        end
    end

    // Next-state and per-cycle stall/done decode
    always_comb begin
        state_next = state;
        stall_c    = STALL_NONE;
        done_c     = 1'b0;
        pc_capture = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_clear  = 1'b0;

        case (state)
            ST_RUN: begin
                if (bus.flush_req) begin
                    // Flush wins over a same-cycle multi-cycle start
                    pc_capture = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = ST_FLUSH;
                end else if (bus.ex_mc_start && mc_multi) begin
                    stall_c    = STALL_EXBUSY;
                    cnt_load   = 1'b1;
                    state_next = ST_EXBUSY;
                end else if (bus.stallreq_id) begin
                    // A single-cycle EX op does not hide a load-use hazard
                    stall_c = STALL_LOADUSE;
                end
            end

            ST_EXBUSY: begin
                if (bus.flush_req) begin
                    // Pending count is abandoned and no done pulse is raised
                    pc_capture = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = ST_FLUSH;
                end else if (cnt_one) begin
                    done_c     = 1'b1;
                    cnt_dec    = 1'b1;
                    stall_c    = bus.stallreq_id ? STALL_LOADUSE : STALL_NONE;
                    state_next = ST_RUN;
                end else begin
                    // EXBUSY stall already holds ID, so stallreq_id is covered
                    stall_c = STALL_EXBUSY;
                    cnt_dec = 1'b1;
                end
            end

            ST_FLUSH: begin
                if (bus.flush_req) begin
                    pc_capture = 1'b1;
                    state_next = ST_FLUSH;
                end else begin
                    state_next = ST_RUN;
                end
            end

            default: begin
                cnt_clear  = 1'b1;
                state_next = ST_RUN;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is held so that
    // asserted request inputs cannot leak through during reset
    assign bus.stall      = rst ? stall_c : STALL_NONE;
    assign bus.ex_mc_done = rst & done_c;
    assign bus.flush      = rst & (state == ST_FLUSH);
    assign bus.busy       = rst & (state != ST_RUN);
    assign bus.new_pc     = new_pc_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, load-use, multi-cycle EX, abort,
// collision, back-to-back flush, edge lengths, async reset mid-operation.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int MC_CNT_W = 6;

    logic        clk;
    logic        rst;
    logic [1:0]  dbg_state;

    int n_cmp;
    int n_err;
    logic [31:0] exp_pc;

    pipe_ctrl_if #(.MC_CNT_W(MC_CNT_W)) bus ();

    pipe_ctrl #(.MC_CNT_W(MC_CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Compare every control output at once
    task automatic chk_out(input string tag, input logic [5:0] st, input logic fl,
                           input logic dn, input logic bz, input logic [31:0] pc);
        chk({tag, ".stall"}, 32'(bus.stall), 32'(st));
        chk({tag, ".flush"}, 32'(bus.flush), 32'(fl));
        chk({tag, ".done"},  32'(bus.ex_mc_done), 32'(dn));
        chk({tag, ".busy"},  32'(bus.busy), 32'(bz));
        chk({tag, ".new_pc"}, bus.new_pc, pc);
    endtask

    // Drive inputs mid-cycle and let combinational outputs settle
    task automatic drive(input logic sr, input logic st, input logic [5:0] n,
                         input logic fr, input logic [31:0] pc);
        @(negedge clk);
        bus.stallreq_id  = sr;
        bus.ex_mc_start  = st;
        bus.ex_mc_cycles = n;
        bus.flush_req    = fr;
        bus.flush_pc     = pc;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        exp_pc = 32'h0;
        rst    = 1'b0;
        bus.stallreq_id  = 1'b1;
        bus.ex_mc_start  = 1'b1;
        bus.ex_mc_cycles = 6'd7;
        bus.flush_req    = 1'b1;
        bus.flush_pc     = 32'hFFFF_FFFF;

        // Reset held with all inputs high: everything zero
        #3;
        chk_out("reset_hold", STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        chk_out("reset_edge", STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("reset_state", 32'(dbg_state), 32'(ST_RUN));

        // Release reset with idle inputs
        @(negedge clk);
        bus.stallreq_id = 1'b0; bus.ex_mc_start = 1'b0; bus.flush_req = 1'b0;
        bus.ex_mc_cycles = 6'd0; bus.flush_pc = 32'h0;
        rst = 1'b1;
        #1;
        chk_out("post_reset", STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);

        // Load-use: one cycle of 000111, busy stays low
        drive(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
        chk_out("loaduse", STALL_LOADUSE, 1'b0, 1'b0, 1'b0, exp_pc);
        idle();
        chk_out("loaduse_after", STALL_NONE, 1'b0, 1'b0, 1'b0, exp_pc);
        chk("loaduse_state", 32'(dbg_state), 32'(ST_RUN));

        // Divide N=5: stall 4 cycles, done on 5th, busy 4 cycles
        drive(1'b0, 1'b1, 6'd5, 1'b0, 32'h0);
        chk_out("div_start", STALL_EXBUSY, 1'b0, 1'b0, 1'b0, exp_pc);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk_out("div_busy", STALL_EXBUSY, 1'b0, 1'b0, 1'b1, exp_pc);
        end
        idle();
        chk_out("div_done", STALL_NONE, 1'b0, 1'b1, 1'b1, exp_pc);
        idle();
        chk_out("div_after", STALL_NONE, 1'b0, 1'b0, 1'b0, exp_pc);

        // Abort: N=10, flush on 3rd EXBUSY cycle
        drive(1'b0, 1'b1, 6'd10, 1'b0, 32'h0);
        chk_out("abort_start", STALL_EXBUSY, 1'b0, 1'b0, 1'b0, exp_pc);
        idle();
        chk_out("abort_busy1", STALL_EXBUSY, 1'b0, 1'b0, 1'b1, exp_pc);
        idle();
        chk_out("abort_busy2", STALL_EXBUSY, 1'b0, 1'b0, 1'b1, exp_pc);
        drive(1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0180);
        chk("abort_req.done", 32'(bus.ex_mc_done), 32'd0);
        chk("abort_req.busy", 32'(bus.busy), 32'd1);
        exp_pc = 32'h0000_0180;
        idle();
        chk_out("abort_flush", STALL_NONE, 1'b1, 1'b0, 1'b1, exp_pc);
        chk("abort_flush_state", 32'(dbg_state), 32'(ST_FLUSH));
        for (int i = 0; i < 10; i++) begin
            idle();
            chk_out("abort_run", STALL_NONE, 1'b0, 1'b0, 1'b0, exp_pc);
        end

        // Collision: ex_mc_start N=4 with flush_req, flush wins
        drive(1'b0, 1'b1, 6'd4, 1'b1, 32'h0000_0200);
        exp_pc = 32'h0000_0200;
        idle();
        chk_out("coll_flush", STALL_NONE, 1'b1, 1'b0, 1'b1, exp_pc);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk_out("coll_run", STALL_NONE, 1'b0, 1'b0, 1'b0, exp_pc);
            chk("coll_state", 32'(dbg_state), 32'(ST_RUN));
        end

        // Back-to-back flush: second request repeats FLUSH with new PC
        drive(1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0300);
        drive(1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0400);
        chk_out("b2b_flush1", STALL_NONE, 1'b1, 1'b0, 1'b1, 32'h0000_0300);
        idle();
        exp_pc = 32'h0000_0400;
        chk_out("b2b_flush2", STALL_NONE, 1'b1, 1'b0, 1'b1, exp_pc);
        idle();
        chk_out("b2b_run", STALL_NONE, 1'b0, 1'b0, 1'b0, exp_pc);

        // Edge lengths N=0 and N=1: no stall, no done
        drive(1'b0, 1'b1, 6'd0, 1'b0, 32'h0);
        chk_out("n0_start", STALL_NONE, 1'b0, 1'b0, 1'b0, exp_pc);
        idle();
        chk_out("n0_next", STALL_NONE, 1'b0, 1'b0, 1'b0, exp_pc);
        drive(1'b0, 1'b1, 6'd1, 1'b0, 32'h0);
        chk_out("n1_start", STALL_NONE, 1'b0, 1'b0, 1'b0, exp_pc);
        idle();
        chk_out("n1_next", STALL_NONE, 1'b0, 1'b0, 1'b0, exp_pc);

        // N=2: one stall cycle, done on the next
        drive(1'b0, 1'b1, 6'd2, 1'b0, 32'h0);
        chk_out("n2_start", STALL_EXBUSY, 1'b0, 1'b0, 1'b0, exp_pc);
        idle();
        chk_out("n2_done", STALL_NONE, 1'b0, 1'b1, 1'b1, exp_pc);
        idle();
        chk_out("n2_after", STALL_NONE, 1'b0, 1'b0, 1'b0, exp_pc);

        // N=3 with load-use on the done cycle, ignored load-use while busy
        drive(1'b0, 1'b1, 6'd3, 1'b0, 32'h0);
        chk_out("n3_start", STALL_EXBUSY, 1'b0, 1'b0, 1'b0, exp_pc);
        drive(1'b1, 1'b1, 6'd7, 1'b0, 32'h0);
        chk_out("n3_busy", STALL_EXBUSY, 1'b0, 1'b0, 1'b1, exp_pc);
        drive(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
        chk_out("n3_done_lu", STALL_LOADUSE, 1'b0, 1'b1, 1'b1, exp_pc);
        idle();
        chk_out("n3_after", STALL_NONE, 1'b0, 1'b0, 1'b0, exp_pc);

        // Async reset mid-EXBUSY with all inputs high
        drive(1'b0, 1'b1, 6'd10, 1'b0, 32'h0);
        idle();
        idle();
        chk("mid_busy_state", 32'(dbg_state), 32'(ST_EXBUSY));
        drive(1'b1, 1'b1, 6'd63, 1'b1, 32'hDEAD_BEEF);
        #1;
        rst = 1'b0;
        #1;
        exp_pc = 32'h0;
        chk_out("async_rst_busy", STALL_NONE, 1'b0, 1'b0, 1'b0, exp_pc);
        chk("async_rst_state", 32'(dbg_state), 32'(ST_RUN));
        @(negedge clk);
        bus.stallreq_id = 1'b0; bus.ex_mc_start = 1'b0; bus.flush_req = 1'b0;
        bus.ex_mc_cycles = 6'd0; bus.flush_pc = 32'h0;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            idle();
            chk_out("rst_busy_after", STALL_NONE, 1'b0, 1'b0, 1'b0, exp_pc);
        end

        // Async reset mid-FLUSH: flush drops at once, no pulse after release
        drive(1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0500);
        idle();
        chk_out("pre_rst_flush", STALL_NONE, 1'b1, 1'b0, 1'b1, 32'h0000_0500);
        #2;
        rst = 1'b0;
        #1;
        chk_out("async_rst_flush", STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk_out("rst_flush_after", STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
